// File: rtl/mpf_vtp_translate_multi_chan.sv
// mpf_vtp_translate_multi_chan: per-channel in-order VA->PA translation with request/response FIFOs and a registered output stage.
// Define MPF_VTP_TRANSLATE_STATS_EN to add saturating stat_xlate/stat_err counters.
module mpf_vtp_translate_multi_chan #(
  parameter int NUM_CHAN      = 2,
  parameter int ADDR_W        = 42,
  parameter int PAYLOAD_W     = 64,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4,
  parameter int FAIL_ON_ERROR = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CHAN-1:0]           in_valid,
  input  logic [NUM_CHAN*ADDR_W-1:0]    in_addr,
  input  logic [NUM_CHAN-1:0]           in_is_virtual,
  input  logic [NUM_CHAN*PAYLOAD_W-1:0] in_payload,
  output logic [NUM_CHAN-1:0]           in_almost_full,
  output logic [NUM_CHAN-1:0]           vtp_req_valid,
  output logic [NUM_CHAN*ADDR_W-1:0]    vtp_req_addr,
  input  logic [NUM_CHAN-1:0]           vtp_req_almost_full,
  input  logic [NUM_CHAN-1:0]           vtp_rsp_valid,
  input  logic [NUM_CHAN*ADDR_W-1:0]    vtp_rsp_addr,
  input  logic [NUM_CHAN-1:0]           vtp_rsp_error,
  output logic [NUM_CHAN-1:0]           out_valid,
  input  logic [NUM_CHAN-1:0]           out_ready,
  output logic [NUM_CHAN*ADDR_W-1:0]    out_addr,
  output logic [NUM_CHAN*PAYLOAD_W-1:0] out_payload,
  output logic [NUM_CHAN-1:0]           out_error,
  output logic [NUM_CHAN-1:0]           error,
  output logic [NUM_CHAN-1:0]           overflow
`ifdef MPF_VTP_TRANSLATE_STATS_EN
  ,
  output logic [NUM_CHAN*32-1:0]        stat_xlate,
  output logic [NUM_CHAN*32-1:0]        stat_err
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = ADDR_W + PAYLOAD_W + 1;
  localparam int SW = ADDR_W + 1;

  // Stale responses from before reset are dropped silently until DEPTH cycles have elapsed.
  logic [CW-1:0] grace_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) grace_q <= '0;
    else if (grace_q != CW'(DEPTH)) grace_q <= grace_q + 1'b1;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_ch
    logic [RW-1:0] req_mem [DEPTH];
    logic [SW-1:0] rsp_mem [DEPTH];
    logic [PW-1:0] req_wr_q, req_rd_q, rsp_wr_q, rsp_rd_q;
    logic [CW-1:0] req_cnt_q, rsp_cnt_q, outst_q, occ, occ_d, req_cnt_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic out_valid_q, out_error_q, error_q, overflow_q, almfull_q;
    logic [RW-1:0] in_ent, head;
    logic [SW-1:0] rsp_ent, rsp_head;
    logic full, push, vreq, rsp_push, h_virt, h_err, load, drop, out_valid_d, ovf_set;
    assign in_ent  = {in_addr[c*ADDR_W +: ADDR_W], in_payload[c*PAYLOAD_W +: PAYLOAD_W], in_is_virtual[c]};
    assign rsp_ent = {vtp_rsp_addr[c*ADDR_W +: ADDR_W], vtp_rsp_error[c]};
    // Occupancy includes the output register so DEPTH requests in total can be held; empty FIFOs bypass straight to it.
    always_comb begin
      occ         = req_cnt_q + CW'(out_valid_q);
      full        = occ == CW'(DEPTH);
      push        = in_valid[c] & ~full;
      vreq        = push & in_is_virtual[c] & reset_n;
      rsp_push    = vtp_rsp_valid[c] & (outst_q != '0) & (rsp_cnt_q != CW'(DEPTH));
      head        = (req_cnt_q != '0) ? req_mem[req_rd_q] : in_ent;
      rsp_head    = (rsp_cnt_q != '0) ? rsp_mem[rsp_rd_q] : rsp_ent;
      h_virt      = head[0];
      h_err       = h_virt & rsp_head[0];
      load        = (~out_valid_q | out_ready[c]) & ((req_cnt_q != '0) | push) & (~h_virt | (rsp_cnt_q != '0) | rsp_push);
      drop        = load & h_err & (FAIL_ON_ERROR != 0);
      out_valid_d = load ? ~drop : out_valid_q & ~out_ready[c];
      req_cnt_d   = req_cnt_q + CW'(push) - CW'(load);
      occ_d       = req_cnt_d + CW'(out_valid_d);
      ovf_set     = (in_valid[c] & full) | (vtp_rsp_valid[c] & ((rsp_cnt_q == CW'(DEPTH)) | ((outst_q == '0) & (grace_q == CW'(DEPTH)))));
    end
    always_ff @(posedge clk) begin
      if (push) req_mem[req_wr_q] <= in_ent;
      if (rsp_push) rsp_mem[rsp_wr_q] <= rsp_ent;
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        req_wr_q <= '0; req_rd_q <= '0; req_cnt_q <= '0;
        rsp_wr_q <= '0; rsp_rd_q <= '0; rsp_cnt_q <= '0;
        outst_q <= '0; out_valid_q <= 1'b0; out_error_q <= 1'b0;
        out_addr_q <= '0; out_payload_q <= '0;
        error_q <= 1'b0; overflow_q <= 1'b0; almfull_q <= 1'b1;
      end else begin
        req_wr_q    <= req_wr_q + PW'(push);
        req_rd_q    <= req_rd_q + PW'(load);
        req_cnt_q   <= req_cnt_d;
        rsp_wr_q    <= rsp_wr_q + PW'(rsp_push);
        rsp_rd_q    <= rsp_rd_q + PW'(load & h_virt);
        rsp_cnt_q   <= rsp_cnt_q + CW'(rsp_push) - CW'(load & h_virt);
        outst_q     <= outst_q + CW'(vreq) - CW'(rsp_push);
        out_valid_q <= out_valid_d;
        if (load & ~drop) begin
          out_addr_q    <= h_virt ? rsp_head[SW-1:1] : head[RW-1 -: ADDR_W];
          out_payload_q <= head[PAYLOAD_W:1];
          out_error_q   <= h_err;
        end
        error_q     <= load & h_err;
        overflow_q  <= overflow_q | ovf_set;
        almfull_q   <= (occ_d >= CW'(DEPTH - ALMFULL_SLACK)) | vtp_req_almost_full[c];
      end
    assign vtp_req_valid[c]                      = vreq;
    assign vtp_req_addr[c*ADDR_W +: ADDR_W]      = in_addr[c*ADDR_W +: ADDR_W];
    assign out_valid[c]                          = out_valid_q;
    assign out_addr[c*ADDR_W +: ADDR_W]          = out_addr_q;
    assign out_payload[c*PAYLOAD_W +: PAYLOAD_W] = out_payload_q;
    assign out_error[c]                          = out_error_q;
    assign error[c]                              = error_q;
    assign overflow[c]                           = overflow_q;
    assign in_almost_full[c]                     = almfull_q;
`ifdef MPF_VTP_TRANSLATE_STATS_EN
    logic [31:0] xlate_q, err_q;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        xlate_q <= '0;
        err_q   <= '0;
      end else begin
        if (load & h_virt & ~&xlate_q) xlate_q <= xlate_q + 1'b1;
        if (load & h_err & ~&err_q) err_q <= err_q + 1'b1;
      end
    assign stat_xlate[c*32 +: 32] = xlate_q;
    assign stat_err[c*32 +: 32]   = err_q;
`endif
  end
endmodule

// File: tb/tb_mpf_vtp_translate_multi_chan.sv
// tb_mpf_vtp_translate_multi_chan: directed checks of ordering, bypass latency, errors, flow control and reset.
module tb_mpf_vtp_translate_multi_chan;
  localparam int AW = 42;
  localparam int PLW = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [1:0] in_valid, in_is_virtual, in_almost_full, vtp_req_valid, vtp_req_almost_full;
  logic [1:0] vtp_rsp_valid, vtp_rsp_error, out_valid, out_ready, out_error, error, overflow;
  logic [2*AW-1:0] in_addr, vtp_req_addr, vtp_rsp_addr, out_addr;
  logic [2*PLW-1:0] in_payload, out_payload;
  logic p_in_valid, p_in_is_virtual, p_in_almost_full, p_vtp_req_valid, p_vtp_req_almost_full;
  logic p_vtp_rsp_valid, p_vtp_rsp_error, p_out_valid, p_out_ready, p_out_error, p_error, p_overflow;
  logic [AW-1:0] p_in_addr, p_vtp_req_addr, p_vtp_rsp_addr, p_out_addr;
  logic [PLW-1:0] p_in_payload, p_out_payload;
  int n_cmp = 0;
  int n_bad = 0;

  mpf_vtp_translate_multi_chan dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_addr(in_addr),
    .in_is_virtual(in_is_virtual), .in_payload(in_payload), .in_almost_full(in_almost_full),
    .vtp_req_valid(vtp_req_valid), .vtp_req_addr(vtp_req_addr), .vtp_req_almost_full(vtp_req_almost_full),
    .vtp_rsp_valid(vtp_rsp_valid), .vtp_rsp_addr(vtp_rsp_addr), .vtp_rsp_error(vtp_rsp_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_payload(out_payload),
    .out_error(out_error), .error(error), .overflow(overflow)
  );

  mpf_vtp_translate_multi_chan #(.NUM_CHAN(1), .FAIL_ON_ERROR(0)) dut_p (
    .clk(clk), .reset_n(reset_n), .in_valid(p_in_valid), .in_addr(p_in_addr),
    .in_is_virtual(p_in_is_virtual), .in_payload(p_in_payload), .in_almost_full(p_in_almost_full),
    .vtp_req_valid(p_vtp_req_valid), .vtp_req_addr(p_vtp_req_addr), .vtp_req_almost_full(p_vtp_req_almost_full),
    .vtp_rsp_valid(p_vtp_rsp_valid), .vtp_rsp_addr(p_vtp_rsp_addr), .vtp_rsp_error(p_vtp_rsp_error),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_addr(p_out_addr), .out_payload(p_out_payload),
    .out_error(p_out_error), .error(p_error), .overflow(p_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    vtp_rsp_valid = '0;
    p_in_valid = 1'b0;
    p_vtp_rsp_valid = 1'b0;
  endtask

  task automatic drive_req(input int ch, input logic [AW-1:0] a, input logic v, input logic [PLW-1:0] p);
    in_valid[ch] = 1'b1;
    in_addr[ch*AW +: AW] = a;
    in_is_virtual[ch] = v;
    in_payload[ch*PLW +: PLW] = p;
  endtask

  task automatic drive_rsp(input int ch, input logic [AW-1:0] a, input logic e);
    vtp_rsp_valid[ch] = 1'b1;
    vtp_rsp_addr[ch*AW +: AW] = a;
    vtp_rsp_error[ch] = e;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = '0; in_addr = '0; in_is_virtual = '0; in_payload = '0;
    vtp_req_almost_full = '0; vtp_rsp_valid = '0; vtp_rsp_addr = '0; vtp_rsp_error = '0; out_ready = 2'b11;
    p_in_valid = 0; p_in_addr = '0; p_in_is_virtual = 0; p_in_payload = '0; p_vtp_req_almost_full = 0;
    p_vtp_rsp_valid = 0; p_vtp_rsp_addr = '0; p_vtp_rsp_error = 0; p_out_ready = 1;
    drive_req(1, 42'h44, 1'b1, 64'h0);
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_almfull", 64'(in_almost_full), 64'h3);
    chk("rst_vtp_req", 64'(vtp_req_valid), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_error", 64'(error), 64'h0);
    idle();
    reset_n = 1'b1;
    tick();
    chk("almfull_release", 64'(in_almost_full), 64'h0);
    // physical request bypasses to the output register in one cycle
    drive_req(0, 42'h100, 1'b0, 64'hAAAA);
    #1 chk("phys_no_vtp", 64'(vtp_req_valid), 64'h0);
    tick(); idle();
    chk("phys_valid", 64'(out_valid), 64'h1);
    chk("phys_addr", 64'(out_addr[0 +: AW]), 64'h100);
    chk("phys_payload", out_payload[0 +: PLW], 64'hAAAA);
    tick();
    chk("phys_popped", 64'(out_valid[0]), 64'h0);
    // virtual request on ch1, response after 5 cycles
    drive_req(1, 42'h2000, 1'b1, 64'h55);
    #1 chk("virt_vtp_valid", 64'(vtp_req_valid), 64'h2);
    chk("virt_vtp_addr", 64'(vtp_req_addr[AW +: AW]), 64'h2000);
    tick(); idle();
    repeat (4) tick();
    chk("virt_wait", 64'(out_valid[1]), 64'h0);
    drive_rsp(1, 42'h7000, 1'b0);
    tick(); idle();
    chk("virt_valid", 64'(out_valid[1]), 64'h1);
    chk("virt_addr", 64'(out_addr[AW +: AW]), 64'h7000);
    chk("virt_payload", out_payload[PLW +: PLW], 64'h55);
    chk("virt_err", 64'(out_error[1]), 64'h0);
    tick();
    chk("virt_popped", 64'(out_valid[1]), 64'h0);
    // ordering: virtual A, physical B, virtual C
    drive_req(0, 42'hA000, 1'b1, 64'h1); tick();
    drive_req(0, 42'hB00, 1'b0, 64'h2); tick();
    drive_req(0, 42'hC000, 1'b1, 64'h3); tick(); idle();
    repeat (5) tick();
    chk("order_b_held", 64'(out_valid[0]), 64'h0);
    drive_rsp(0, 42'h1A000, 1'b0);
    tick(); idle();
    chk("order_a_valid", 64'(out_valid[0]), 64'h1);
    chk("order_a_addr", 64'(out_addr[0 +: AW]), 64'h1A000);
    chk("order_a_payload", out_payload[0 +: PLW], 64'h1);
    out_ready = 2'b10;
    tick();
    chk("hold_valid", 64'(out_valid[0]), 64'h1);
    chk("hold_addr", 64'(out_addr[0 +: AW]), 64'h1A000);
    out_ready = 2'b11;
    tick();
    chk("order_b_addr", 64'(out_addr[0 +: AW]), 64'hB00);
    chk("order_b_payload", out_payload[0 +: PLW], 64'h2);
    tick();
    chk("order_c_wait", 64'(out_valid[0]), 64'h0);
    drive_rsp(0, 42'h1C000, 1'b0);
    tick(); idle();
    chk("order_c_valid", 64'(out_valid[0]), 64'h1);
    chk("order_c_addr", 64'(out_addr[0 +: AW]), 64'h1C000);
    chk("order_c_payload", out_payload[0 +: PLW], 64'h3);
    tick();
    // failed translation: dropped (default) vs passed flagged (dut_p)
    drive_req(0, 42'h3000, 1'b1, 64'h4);
    p_in_valid = 1; p_in_addr = 42'h3000; p_in_is_virtual = 1; p_in_payload = 64'h4;
    tick(); idle(); tick();
    drive_rsp(0, 42'h0, 1'b1);
    p_vtp_rsp_valid = 1; p_vtp_rsp_addr = 42'h0; p_vtp_rsp_error = 1;
    tick(); idle();
    chk("err_pulse", 64'(error), 64'h1);
    chk("err_dropped", 64'(out_valid), 64'h0);
    chk("p_err_valid", 64'(p_out_valid), 64'h1);
    chk("p_err_flag", 64'(p_out_error), 64'h1);
    chk("p_err_pulse", 64'(p_error), 64'h1);
    tick();
    chk("err_pulse_end", 64'(error), 64'h0);
    chk("p_err_pulse_end", 64'(p_error), 64'h0);
    chk("p_err_popped", 64'(p_out_valid), 64'h0);
    // VTP back-pressure propagates to in_almost_full
    vtp_req_almost_full = 2'b01;
    tick();
    chk("vtp_af", 64'(in_almost_full), 64'h1);
    vtp_req_almost_full = 2'b00;
    tick();
    chk("vtp_af_clear", 64'(in_almost_full), 64'h0);
    // fill ch1 with out_ready low
    out_ready = 2'b01;
    for (int i = 0; i < 16; i++) begin
      drive_req(1, AW'(i), 1'b0, 64'(i + 100));
      tick();
      if (i == 10) chk("af_after_11", 64'(in_almost_full[1]), 64'h0);
      if (i == 11) chk("af_after_12", 64'(in_almost_full[1]), 64'h1);
    end
    drive_req(1, 42'h999, 1'b1, 64'h0);
    #1 chk("full_no_vtp", 64'(vtp_req_valid), 64'h0);
    tick(); idle();
    chk("overflow_set", 64'(overflow), 64'h2);
    out_ready = 2'b11;
    for (int i = 0; i < 16; i++) begin
      chk("drain_addr", 64'(out_addr[AW +: AW]), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid[1]), 64'h0);
    chk("overflow_sticky", 64'(overflow), 64'h2);
    // reset mid-stream with outstanding translations
    out_ready = 2'b10;
    drive_req(0, 42'h50, 1'b0, 64'h9); tick();
    for (int i = 0; i < 5; i++) begin
      drive_req(0, AW'(32'h6000 + i), 1'b1, 64'(i));
      tick();
    end
    idle();
    chk("pre_rst_valid", 64'(out_valid), 64'h1);
    #2 reset_n = 1'b0;
    drive_req(0, 42'h77, 1'b1, 64'h0);
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_ovf", 64'(overflow), 64'h0);
    chk("mid_rst_af", 64'(in_almost_full), 64'h3);
    chk("mid_rst_vtp", 64'(vtp_req_valid), 64'h0);
    tick(); idle();
    reset_n = 1'b1;
    out_ready = 2'b11;
    tick();
    chk("post_rst_af", 64'(in_almost_full), 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive_rsp(0, AW'(32'h9000 + i), 1'b0);
      tick();
      chk("stale_ovf", 64'(overflow), 64'h0);
      chk("stale_valid", 64'(out_valid), 64'h0);
    end
    idle();
    repeat (12) tick();
    drive_rsp(0, 42'h1, 1'b0);
    tick(); idle();
    chk("unsolicited_ovf", 64'(overflow), 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
